// File: rtl/ps2_host_tx_if.sv
// CPU-side handshake between the port block and the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] TX_DATA;
   logic       TX_START;
   logic       TX_BUSY;
   logic       TX_DONE;
   logic       TX_ERROR;

   modport master (output TX_DATA, output TX_START, input TX_BUSY, input TX_DONE, input TX_ERROR);
   modport slave  (input TX_DATA, input TX_START, output TX_BUSY, output TX_DONE, output TX_ERROR);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data + parity + stop,
// check the device ACK. Pins are open drain; OE=1 pulls the line low.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int REQ_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int CNT_W          = 20
) (
   input  logic         CLOCK_50,
   input  logic         RESET_N,
   ps2_host_tx_if.slave cpu,
   input  logic         PS2_CLK_IN,
   input  logic         PS2_DAT_IN,
   output logic         PS2_CLK_OE,
   output logic         PS2_DAT_OE
);
   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       shift_q, shift_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [1:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       dat_sync_q, dat_sync_d;
   logic             clk_prev_q, clk_prev_d;

   logic clk_s, dat_s, clk_fall, timeout_hit;

   assign clk_s       = clk_sync_q[1];
   assign dat_s       = dat_sync_q[1];
   assign clk_fall    = clk_prev_q & ~clk_s;
   assign timeout_hit = (cnt_q == TMO_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         bitcnt_q   <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         // Idle-high sync values keep reset release from looking like a clock fall.
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         done_q     <= done_d;
         error_q    <= error_d;
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         clk_prev_q <= clk_prev_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      bitcnt_d   = bitcnt_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      clk_sync_d = {clk_sync_q[0], PS2_CLK_IN};
      dat_sync_d = {dat_sync_q[0], PS2_DAT_IN};
      clk_prev_d = clk_s;

      case (state_q)
         S_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            // A start arriving alongside a completion pulse is dropped, not queued.
            if (cpu.TX_START && !done_q && !error_q) begin
               shift_d  = {1'b1, ~^cpu.TX_DATA, cpu.TX_DATA};
               bitcnt_d = '0;
               cnt_d    = '0;
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               dat_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_REQ;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_REQ: begin
            if (cnt_q == REQ_LAST) begin
               clk_oe_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_SEND;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_SEND: begin
            if (clk_fall) begin
               dat_oe_d = ~shift_q[0];
               shift_d  = {1'b0, shift_q[9:1]};
               bitcnt_d = bitcnt_q + 4'd1;
               cnt_d    = '0;
               if (bitcnt_q == 4'd9) begin
                  state_d = S_ACK;
               end
            end else if (timeout_hit) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_ACK: begin
            if (clk_fall) begin
               cnt_d = '0;
               if (!dat_s) begin
                  state_d = S_WAIT_IDLE;
               end else begin
                  clk_oe_d = 1'b0;
                  dat_oe_d = 1'b0;
                  error_d  = 1'b1;
                  state_d  = S_IDLE;
               end
            end else if (timeout_hit) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT_IDLE: begin
            if (clk_s && dat_s) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (timeout_hit) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   assign cpu.TX_BUSY  = (state_q != S_IDLE);
   assign cpu.TX_DONE  = done_q;
   assign cpu.TX_ERROR = error_q;
   assign PS2_CLK_OE   = clk_oe_q;
   assign PS2_DAT_OE   = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host, decodes them and
// compares against bytes/parity/outcomes predicted from the protocol rules.
module tb_ps2_host_tx;
   localparam int INH = 120;
   localparam int REQ = 4;
   localparam int TMO = 400;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_oe, dat_oe;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   logic ps2_clk, ps2_dat;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_bad = 0, long_cnt = 0;
   int unsigned last_err_cyc = 0;
   logic        prev_pulse = 1'b0;

   always #5 clk = ~clk;

   ps2_host_tx_if cpu_if ();

   // Open-drain wired-AND of host and device on both lines.
   assign ps2_clk = ~(clk_oe | dev_clk_low);
   assign ps2_dat = ~(dat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .REQ_CYCLES     (REQ),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (20)
   ) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .cpu        (cpu_if),
      .PS2_CLK_IN (ps2_clk),
      .PS2_DAT_IN (ps2_dat),
      .PS2_CLK_OE (clk_oe),
      .PS2_DAT_OE (dat_oe)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cpu_if.TX_DONE) done_cnt <= done_cnt + 1;
      if (cpu_if.TX_ERROR) begin
         err_cnt      <= err_cnt + 1;
         last_err_cyc <= cyc;
      end
      if (cpu_if.TX_DONE && cpu_if.TX_ERROR) both_cnt <= both_cnt + 1;
      if ((cpu_if.TX_DONE || cpu_if.TX_ERROR) && cpu_if.TX_BUSY) busy_bad <= busy_bad + 1;
      if ((cpu_if.TX_DONE || cpu_if.TX_ERROR) && prev_pulse) long_cnt <= long_cnt + 1;
      prev_pulse <= cpu_if.TX_DONE || cpu_if.TX_ERROR;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // mode: 0 ACK, 1 no ACK, 2 device stops after 4th bit, 3 restart attempt while busy, 4 reset in SEND
   task automatic run_frame(input logic [7:0] b, input int mode, input int h);
      int          n;
      int          d0, e0;
      logic [9:0]  bits;
      logic        exp_par;
      int unsigned t_fall;
      exp_par = (($countones(b) % 2) == 0);
      bits    = '0;
      t_fall  = 0;
      @(negedge clk);
      cpu_if.TX_DATA  = b;
      cpu_if.TX_START = 1'b1;
      @(negedge clk);
      cpu_if.TX_START = 1'b0;
      cpu_if.TX_DATA  = 8'($urandom);
      check_eq("busy_after_start", cpu_if.TX_BUSY, 1'b1);
      d0 = done_cnt;
      e0 = err_cnt;
      n = 0;
      while (clk_oe && !dat_oe && n < INH + 20) begin
         n++;
         @(negedge clk);
      end
      check_eq("inhibit_len", n, INH);
      n = 0;
      while (clk_oe && dat_oe && n < REQ + 20) begin
         n++;
         @(negedge clk);
      end
      check_eq("req_len", n, REQ);
      wait_neg($urandom_range(2, 8));
      check_eq("start_bit", ps2_dat, 1'b0);
      for (int i = 0; i < 10; i++) begin
         dev_clk_low = 1'b1;
         if (i == 3) t_fall = cyc;
         if (mode == 4 && i == 5) begin
            wait_neg(h / 2);
            rst_n = 1'b0;
            @(negedge clk);
            check_eq("rst_clk_oe", clk_oe, 1'b0);
            check_eq("rst_dat_oe", dat_oe, 1'b0);
            check_eq("rst_busy", cpu_if.TX_BUSY, 1'b0);
            check_eq("rst_no_pulse", {cpu_if.TX_DONE, cpu_if.TX_ERROR}, 2'b00);
            dev_clk_low = 1'b0;
            wait_neg(2);
            rst_n = 1'b1;
            wait_neg(4);
            check_eq("rst_done_cnt", done_cnt, d0);
            check_eq("rst_err_cnt", err_cnt, e0);
            return;
         end
         if (mode == 3 && i == 3) begin
            cpu_if.TX_DATA  = 8'h55;
            cpu_if.TX_START = 1'b1;
            @(negedge clk);
            cpu_if.TX_START = 1'b0;
            wait_neg(h - 1);
         end else begin
            wait_neg(h);
         end
         dev_clk_low = 1'b0;
         bits[i]     = ps2_dat;
         wait_neg(h);
         if (mode == 2 && i == 3) break;
      end
      if (mode == 2) begin
         wait_neg(TMO + 20);
         check_eq("tmo_err_cnt", err_cnt - e0, 1);
         check_eq("tmo_latency", last_err_cyc - t_fall, TMO + 3);
      end else begin
         check_eq("data_byte", bits[7:0], b);
         check_eq("parity_bit", bits[8], exp_par);
         check_eq("stop_bit", bits[9], 1'b1);
         if (mode != 1) dev_dat_low = 1'b1;
         wait_neg(2);
         dev_clk_low = 1'b1;
         wait_neg(h);
         dev_clk_low = 1'b0;
         dev_dat_low = 1'b0;
         wait_neg(h);
         check_eq("done_cnt", done_cnt - d0, (mode == 1) ? 0 : 1);
         check_eq("err_cnt", err_cnt - e0, (mode == 1) ? 1 : 0);
      end
      check_eq("end_busy", cpu_if.TX_BUSY, 1'b0);
      check_eq("end_clk_oe", clk_oe, 1'b0);
      check_eq("end_dat_oe", dat_oe, 1'b0);
   endtask

   initial begin
      cpu_if.TX_DATA  = 8'h00;
      cpu_if.TX_START = 1'b0;
      rst_n = 1'b0;
      wait_neg(4);
      check_eq("reset_clk_oe", clk_oe, 1'b0);
      check_eq("reset_dat_oe", dat_oe, 1'b0);
      check_eq("reset_busy", cpu_if.TX_BUSY, 1'b0);
      check_eq("reset_pulses", {cpu_if.TX_DONE, cpu_if.TX_ERROR}, 2'b00);
      rst_n = 1'b1;
      wait_neg(5);

      run_frame(8'hED, 0, 20);
      run_frame(8'h00, 0, 15);
      run_frame(8'hFF, 0, 25);
      run_frame(8'h01, 0, 12);
      run_frame(8'hA5, 1, 18);
      run_frame(8'h3C, 2, 20);
      run_frame(8'hED, 3, 16);
      run_frame(8'h5A, 4, 20);
      run_frame(8'hF4, 0, 20);
      for (int k = 0; k < 12; k++) begin
         run_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(10, 30));
      end

      wait_neg(2);
      check_eq("both_pulses", both_cnt, 0);
      check_eq("busy_at_pulse", busy_bad, 0);
      check_eq("pulse_width", long_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
